conv_window_enable_gen: RTL and testbench
=========================================

Name: conv_window_enable_gen

Overview:
Successor to the 1-D conv enable generator. Tracks a raster-scanned pixel stream over a full 2-D frame with runtime image width and height, patch size and stride. Asserts conv_enable exactly on pixels that complete a stride-aligned PxP window, and reports window coordinates and end of frame. Sits between the pixel/patch buffer and the clause/convolution engine in the accelerator datapath.

Parameters:
DIM_W, 8, width of image-dimension and position counters (frame up to 2^DIM_W-1 per side)
K_W, 3, width of patch_size and stride fields (max 7)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; latches config and begins a frame (IDLE/DONE only)
img_width  in  DIM_W  pixels per row
img_height  in  DIM_W  rows per frame
patch_size  in  K_W  window side P
stride  in  K_W  window step S, both axes
pix_valid  in  1  one pixel of raster stream accepted this cycle
conv_enable  out  1  window ending at the current pixel is valid
win_col  out  DIM_W  horizontal window index of the asserted enable
win_row  out  DIM_W  vertical window index of the asserted enable
frame_done  out  1  one-cycle pulse after the last pixel of the frame
busy  out  1  high in RUN
cfg_err  out  1  one-cycle pulse on rejected start

Behaviour:
- Reset (rst low, async): state IDLE; all counters 0; conv_enable, win_col, win_row, frame_done, busy, cfg_err all 0.
- States: IDLE -> RUN on valid start; RUN -> DONE after last pixel; DONE -> RUN on valid start, else DONE -> IDLE next cycle.
- Config check at start: reject if P==0, S==0, P>img_width, or P>img_height. On reject: cfg_err=1 for one cycle, state unchanged, nothing latched. Accepted config is held constant for the whole frame.
- start in RUN is ignored (no error, no relatch).
- Position counters col, row count pix_valid cycles only; col wraps to 0 at img_width-1 and row increments. Gaps in pix_valid freeze all counters.
- Stride phase counters hph and vph: start at 0 once col>=P-1 (resp. row>=P-1), increment mod S per eligible pixel or row, and reset to 0 at each row start (hph) or frame start (vph). No divider or modulo hardware.
- Window condition for the pixel at (row,col): col>=P-1 and row>=P-1 and hph==0 and vph==0.
- Latency 1: conv_enable, win_col, win_row are registered and reflect the pix_valid of the previous cycle. conv_enable is 0 in any cycle following pix_valid=0.
- win_col = number of windows already emitted in the current row; reset per row. win_row = window rows completed; reset per frame. Both hold their value when conv_enable=0.
- Last pixel is (img_height-1, img_width-1): frame_done pulses on the same cycle as that pixel's registered conv_enable, and state goes to DONE. pix_valid in IDLE/DONE is ignored.
- S>P is legal: windows skip pixels. 1x1 frame with P=1 gives exactly one enable plus frame_done.
- Counter widths are sized so no overflow occurs for any legal config. Comparisons are unsigned with P-1 zero-extended.

Decomposition:
- Shared package conv_pkg: state enum (IDLE, RUN, DONE), DIM_W/K_W defaults, config-check function.
- One natural sub-module: stride_phase_ctr (mod-S counter with enable, clear and threshold gate), instantiated twice for the horizontal and vertical axes.

Test Plan:
- 5x5 frame, P=3, S=1, continuous pix_valid -> 9 enables, at pixels (2,2..4),(3,2..4),(4,2..4), each 1 cycle after the pixel. win_col 0,1,2 per row; win_row 0,1,2. frame_done with the last enable.
- 5x5 frame, P=3, S=2 -> exactly 4 enables at (2,2),(2,4),(4,2),(4,4) with (win_row,win_col) = (0,0),(0,1),(1,0),(1,1).
- Same as the S=1 case with pix_valid low every other cycle -> identical enable sequence, each enable 1 cycle after its valid pixel. No enable follows a pix_valid=0 cycle.
- start with P=4, img_width=3 -> cfg_err single pulse, busy stays 0. start with S=0 -> cfg_err. Then a valid start -> busy=1.
- Reset asserted mid-frame at pixel (3,1) -> all outputs 0 immediately. After release and a new start, the frame restarts at (0,0) and gives the full 9 enables.
- Back-to-back frames: start in the DONE cycle with an 8x4 frame, P=2, S=3 -> new config latched, 3x1 = 3 enables at (1,1),(1,4),(1,7), then frame_done.

Source files
------------

// File: rtl/conv_window_enable_gen_pkg.sv
// conv_pkg: types and helpers shared by the 2-D conv window enable generator.
//   state_t    : frame FSM state (IDLE, RUN, DONE)
//   DIM_W_DEF  : default width of image dimensions and position counters
//   K_W_DEF    : default width of patch size / stride fields
//   cfg_ok()   : start-time configuration check, arguments zero-extended to CFG_W
package conv_pkg;

   localparam int DIM_W_DEF = 8;
   localparam int K_W_DEF   = 3;
   localparam int CFG_W     = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // A frame is runnable only if the patch is non-empty, the step is non-zero
   // and a PxP patch fits inside the image on both axes.
   function automatic logic cfg_ok(input logic [CFG_W-1:0] p,
                                   input logic [CFG_W-1:0] s,
                                   input logic [CFG_W-1:0] w,
                                   input logic [CFG_W-1:0] h);
      return (p != '0) && (s != '0) && (p <= w) && (p <= h);
   endfunction

endpackage

// File: rtl/conv_window_enable_gen_stride_phase_ctr.sv
// stride_phase_ctr: modulo-S phase counter for one scan axis.
//   clk, rst : clock, asynchronous active-low reset
//   clear    : force phase to 0 (row start / frame start)
//   step     : one position advance on this axis
//   pos      : current position on this axis
//   thresh   : first eligible position (P-1)
//   stride   : step size S (non-zero while in use)
//   hit      : position is eligible and phase is 0, i.e. stride-aligned
module stride_phase_ctr #(
   parameter int POS_W = 8,
   parameter int K_W   = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             step,
   input  logic [POS_W-1:0] pos,
   input  logic [K_W-1:0]   thresh,
   input  logic [K_W-1:0]   stride,
   output logic             hit
);

   logic [K_W-1:0] phase;
   logic           past_thr;

   // The phase sits at 0 until the threshold is reached, so the first
   // eligible position is always aligned without any subtraction.
   assign past_thr = (pos >= POS_W'(thresh));
   assign hit      = past_thr && (phase == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase <= '0;
      end else if (clear) begin
         phase <= '0;
      end else if (step && past_thr) begin
         phase <= (phase == stride - 1'b1) ? '0 : phase + 1'b1;
      end
   end

endmodule

// File: rtl/conv_window_enable_gen.sv
// conv_window_enable_gen: 2-D raster window enable generator.
// Tracks a raster pixel stream over a frame and flags each pixel that
// completes a stride-aligned PxP window, one cycle after that pixel.
//   clk, rst        : clock, asynchronous active-low reset
//   start           : latch config and begin a frame (ignored while busy)
//   img_width/height: frame dimensions
//   patch_size      : window side P
//   stride          : window step S on both axes
//   pix_valid       : one raster pixel accepted this cycle
//   conv_enable     : registered window-complete flag
//   win_col/win_row : window indices of the last asserted enable
//   frame_done      : pulse with the last pixel's registered result
//   busy            : frame in progress
//   cfg_err         : pulse on a rejected start
module conv_window_enable_gen
   import conv_pkg::*;
#(
   parameter int DIM_W = DIM_W_DEF,
   parameter int K_W   = K_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DIM_W-1:0] img_width,
   input  logic [DIM_W-1:0] img_height,
   input  logic [K_W-1:0]   patch_size,
   input  logic [K_W-1:0]   stride,
   input  logic             pix_valid,
   output logic             conv_enable,
   output logic [DIM_W-1:0] win_col,
   output logic [DIM_W-1:0] win_row,
   output logic             frame_done,
   output logic             busy,
   output logic             cfg_err
);

   state_t           state;
   logic [DIM_W-1:0] cfg_w;
   logic [DIM_W-1:0] cfg_h;
   logic [K_W-1:0]   cfg_p;
   logic [K_W-1:0]   cfg_s;
   logic [K_W-1:0]   p_m1;

   logic [DIM_W-1:0] col;
   logic [DIM_W-1:0] row;
   logic [DIM_W-1:0] wc_cnt;     // windows emitted so far in this row
   logic [DIM_W-1:0] wr_cnt;     // window rows completed so far in this frame

   logic             start_req;
   logic             start_good;
   logic             start_ok;
   logic             start_bad;
   logic             pix_go;
   logic             row_end;
   logic             frame_end;
   logic             h_hit;
   logic             v_hit;
   logic             win_hit;

   assign p_m1 = cfg_p - 1'b1;

   assign start_req  = start && (state != RUN);
   assign start_good = cfg_ok(CFG_W'(patch_size), CFG_W'(stride),
                              CFG_W'(img_width), CFG_W'(img_height));
   assign start_ok   = start_req && start_good;
   assign start_bad  = start_req && !start_good;

   assign pix_go    = (state == RUN) && pix_valid;
   assign row_end   = pix_go && (col == cfg_w - 1'b1);
   assign frame_end = row_end && (row == cfg_h - 1'b1);
   assign win_hit   = h_hit && v_hit;

   // Horizontal phase restarts every row; vertical phase only per frame.
   stride_phase_ctr #(.POS_W(DIM_W), .K_W(K_W)) u_hph (
      .clk    (clk),
      .rst    (rst),
      .clear  (start_ok || row_end),
      .step   (pix_go),
      .pos    (col),
      .thresh (p_m1),
      .stride (cfg_s),
      .hit    (h_hit)
   );

   stride_phase_ctr #(.POS_W(DIM_W), .K_W(K_W)) u_vph (
      .clk    (clk),
      .rst    (rst),
      .clear  (start_ok),
      .step   (row_end),
      .pos    (row),
      .thresh (p_m1),
      .stride (cfg_s),
      .hit    (v_hit)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cfg_w       <= '0;
         cfg_h       <= '0;
         cfg_p       <= '0;
         cfg_s       <= '0;
         col         <= '0;
         row         <= '0;
         wc_cnt      <= '0;
         wr_cnt      <= '0;
         conv_enable <= 1'b0;
         win_col     <= '0;
         win_row     <= '0;
         frame_done  <= 1'b0;
         busy        <= 1'b0;
         cfg_err     <= 1'b0;
      end else begin
         cfg_err     <= start_bad;
         conv_enable <= 1'b0;
         frame_done  <= 1'b0;

         if (start_ok) begin
            cfg_w  <= img_width;
            cfg_h  <= img_height;
            cfg_p  <= patch_size;
            cfg_s  <= stride;
            col    <= '0;
            row    <= '0;
            wc_cnt <= '0;
            wr_cnt <= '0;
            state  <= RUN;
            busy   <= 1'b1;
         end else if (state == RUN) begin
            if (pix_go) begin
               conv_enable <= win_hit;
               if (win_hit) begin
                  win_col <= wc_cnt;
                  win_row <= wr_cnt;
                  wc_cnt  <= wc_cnt + 1'b1;
               end
               if (row_end) begin
                  col    <= '0;
                  wc_cnt <= '0;
                  // Every aligned row holds at least one window since P<=width.
                  if (v_hit) begin
                     wr_cnt <= wr_cnt + 1'b1;
                  end
                  if (frame_end) begin
                     row        <= '0;
                     state      <= DONE;
                     busy       <= 1'b0;
                     frame_done <= 1'b1;
                  end else begin
                     row <= row + 1'b1;
                  end
               end else begin
                  col <= col + 1'b1;
               end
            end
         end else if (state == DONE) begin
            state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_conv_window_enable_gen.sv
// Scoreboard bench for conv_window_enable_gen. The driver pushes expected
// window events computed from the window geometry (mod/div arithmetic);
// the monitor pops and compares whenever the DUT flags an output.
module tb_conv_window_enable_gen;

   localparam int DIM_W = 8;
   localparam int K_W   = 3;

   logic             clk;
   logic             rst;
   logic             start;
   logic [DIM_W-1:0] img_width;
   logic [DIM_W-1:0] img_height;
   logic [K_W-1:0]   patch_size;
   logic [K_W-1:0]   stride;
   logic             pix_valid;
   logic             conv_enable;
   logic [DIM_W-1:0] win_col;
   logic [DIM_W-1:0] win_row;
   logic             frame_done;
   logic             busy;
   logic             cfg_err;

   conv_window_enable_gen #(.DIM_W(DIM_W), .K_W(K_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .img_width   (img_width),
      .img_height  (img_height),
      .patch_size  (patch_size),
      .stride      (stride),
      .pix_valid   (pix_valid),
      .conv_enable (conv_enable),
      .win_col     (win_col),
      .win_row     (win_row),
      .frame_done  (frame_done),
      .busy        (busy),
      .cfg_err     (cfg_err)
   );

   typedef struct {
      bit en;
      bit fd;
      int wc;
      int wr;
      int cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   fails  = 0;
   int   cyc    = 0;
   logic pv_q   = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc  <= cyc + 1;
      pv_q <= pix_valid;
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: compares every flagged DUT output against the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         if (!pv_q) chk("no_enable_after_gap", int'(conv_enable), 0);
         if (conv_enable || frame_done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("conv_enable", int'(conv_enable), int'(e.en));
               chk("frame_done", int'(frame_done), int'(e.fd));
               chk("latency_cycle", cyc, e.cyc);
               if (e.en) begin
                  chk("win_col", int'(win_col), e.wc);
                  chk("win_row", int'(win_row), e.wr);
               end
            end
         end
      end
   end

   task automatic start_frame(input int w, input int h, input int p, input int s,
                              input bit expect_ok);
      img_width  = DIM_W'(w);
      img_height = DIM_W'(h);
      patch_size = K_W'(p);
      stride     = K_W'(s);
      start      = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("cfg_err_on_start", int'(cfg_err), expect_ok ? 0 : 1);
      chk("busy_after_start", int'(busy), expect_ok ? 1 : 0);
   endtask

   // gap_mode: 0 continuous, 1 idle before every pixel, 2 random idles.
   task automatic stream_frame(input int w, input int h, input int p, input int s,
                               input int gap_mode, input int abort_r, input int abort_c,
                               input bit poke);
      int n = 0;
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            int idles;
            bit win;
            bit last;
            if (r == abort_r && c == abort_c) begin
               chk("queue_empty_before_reset", exp_q.size(), 0);
               pix_valid = 1'b0;
               rst = 1'b0;
               #1;
               chk("rst_conv_enable", int'(conv_enable), 0);
               chk("rst_win_col", int'(win_col), 0);
               chk("rst_win_row", int'(win_row), 0);
               chk("rst_frame_done", int'(frame_done), 0);
               chk("rst_busy", int'(busy), 0);
               chk("rst_cfg_err", int'(cfg_err), 0);
               exp_q.delete();
               @(posedge clk); #1;
               rst = 1'b1;
               @(posedge clk); #1;
               return;
            end
            idles = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int k = 0; k < idles; k++) begin
               pix_valid = 1'b0;
               @(posedge clk); #1;
            end
            pix_valid = 1'b1;
            win  = (c >= p - 1) && (r >= p - 1) &&
                   ((c - (p - 1)) % s == 0) && ((r - (p - 1)) % s == 0);
            last = (r == h - 1) && (c == w - 1);
            if (win || last) begin
               exp_t e;
               e.en  = win;
               e.fd  = last;
               e.wc  = win ? (c - (p - 1)) / s : 0;
               e.wr  = win ? (r - (p - 1)) / s : 0;
               e.cyc = cyc + 1;
               exp_q.push_back(e);
            end
            if (poke && n == 3) begin
               start      = 1'b1;
               patch_size = '0;
               img_width  = DIM_W'(1);
            end
            @(posedge clk); #1;
            if (poke && n == 3) begin
               start = 1'b0;
               chk("start_in_run_no_err", int'(cfg_err), 0);
               chk("start_in_run_busy", int'(busy), 1);
            end
            n++;
         end
      end
      pix_valid = 1'b0;
   endtask

   task automatic drain();
      repeat (2) @(posedge clk);
      #1;
      chk("scoreboard_drained", exp_q.size(), 0);
      chk("idle_after_frame", int'(busy), 0);
      exp_q.delete();
   endtask

   initial begin
      rst        = 1'b0;
      start      = 1'b0;
      pix_valid  = 1'b0;
      img_width  = '0;
      img_height = '0;
      patch_size = '0;
      stride     = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_conv_enable", int'(conv_enable), 0);
      chk("reset_win_col", int'(win_col), 0);
      chk("reset_win_row", int'(win_row), 0);
      chk("reset_frame_done", int'(frame_done), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_cfg_err", int'(cfg_err), 0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Rejected starts, then a valid 5x5 P=3 S=1 frame.
      start_frame(3, 5, 4, 1, 1'b0);
      @(posedge clk); #1;
      chk("cfg_err_single_pulse", int'(cfg_err), 0);
      chk("busy_stays_low", int'(busy), 0);
      start_frame(5, 5, 3, 0, 1'b0);
      start_frame(5, 5, 3, 1, 1'b1);
      stream_frame(5, 5, 3, 1, 0, -1, -1, 1'b0);
      drain();

      // Stride 2 skips alternate positions.
      start_frame(5, 5, 3, 2, 1'b1);
      stream_frame(5, 5, 3, 2, 0, -1, -1, 1'b0);
      drain();

      // Gapped stream with an ignored start mid-frame.
      start_frame(5, 5, 3, 1, 1'b1);
      stream_frame(5, 5, 3, 1, 1, -1, -1, 1'b1);
      drain();

      // Reset mid-frame at (3,1), then a complete frame.
      start_frame(5, 5, 3, 1, 1'b1);
      stream_frame(5, 5, 3, 1, 0, 3, 1, 1'b0);
      start_frame(5, 5, 3, 1, 1'b1);
      stream_frame(5, 5, 3, 1, 0, -1, -1, 1'b0);

      // Back-to-back: restart in the DONE cycle with a new config.
      start_frame(8, 4, 2, 3, 1'b1);
      stream_frame(8, 4, 2, 3, 0, -1, -1, 1'b0);
      drain();

      // Single-pixel frame.
      start_frame(1, 1, 1, 1, 1'b1);
      stream_frame(1, 1, 1, 1, 0, -1, -1, 1'b0);
      drain();

      // Randomized legal configurations with random gaps.
      for (int t = 0; t < 8; t++) begin
         int w, h, p, s, pmax;
         w    = int'($urandom_range(1, 12));
         h    = int'($urandom_range(1, 12));
         pmax = (w < h) ? w : h;
         if (pmax > 7) pmax = 7;
         p    = int'($urandom_range(1, pmax));
         s    = int'($urandom_range(1, 7));
         start_frame(w, h, p, s, 1'b1);
         stream_frame(w, h, p, s, 2, -1, -1, 1'b0);
         drain();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
